// File: rtl/mask_gen.sv
// mask_gen: seeded bank of 32-bit Galois LFSRs that produces d random masks
// (each COL_SIZE*PAR bits wide) for share creation, using a valid/ready
// handshake on both the seed input and the mask output.
// Optional feature: define MASK_GEN_COUNTER_EN to add the mask_count output,
// which counts completed mask handshakes.
module mask_gen #(
    parameter int d        = 2,
    parameter int COL_SIZE = 5,
    parameter int PAR      = 1,
    localparam int MASK_W  = d * COL_SIZE * PAR,
    localparam int NL      = (MASK_W + 31) / 32,
    localparam int IDX_W   = (NL > 1) ? $clog2(NL) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid,
    output logic              seed_ready,
    input  logic [31:0]       seed_data,
    output logic              mask_valid,
    input  logic              mask_ready,
    output logic [MASK_W-1:0] random_masks
`ifdef MASK_GEN_COUNTER_EN
    ,output logic [31:0]      mask_count
`endif
);

    localparam logic [31:0] TAPS = 32'h80200003;

    typedef enum logic [1:0] {IDLE, SEED, PRIME, RUN} state_t;

    state_t                 state_q, state_d;
    logic [NL-1:0][31:0]    lfsr_q, lfsr_d, lfsr_adv;
    logic [MASK_W-1:0]      masks_q, masks_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   mask_valid_q, mask_valid_d;
    logic                   seed_ready_q, seed_ready_d;
    logic                   seed_acc;
    logic [31:0]            seed_word;
`ifdef MASK_GEN_COUNTER_EN
    logic [31:0]            cnt_q, cnt_d;
`endif

    // One full 32-step advance of a right-shifting Galois LFSR.
    function automatic logic [31:0] adv32(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 32; i++)
            r = r[0] ? ((r >> 1) ^ TAPS) : (r >> 1);
        return r;
    endfunction

    // Next-state logic: seeding, priming and mask delivery.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        masks_d      = masks_q;
        idx_d        = idx_q;
        mask_valid_d = mask_valid_q;
        seed_ready_d = seed_ready_q;
`ifdef MASK_GEN_COUNTER_EN
        cnt_d        = cnt_q;
`endif
        seed_acc  = seed_valid && seed_ready_q;
        // An all-zero state would lock the LFSR up.
        seed_word = (seed_data == 32'h0) ? 32'h1 : seed_data;
        for (int k = 0; k < NL; k++)
            lfsr_adv[k] = adv32(lfsr_q[k]);

        case (state_q)
            IDLE, RUN: begin
                // A new seed always beats a concurrent mask handshake.
                if (seed_acc) begin
                    lfsr_d[0]    = seed_word;
                    mask_valid_d = 1'b0;
                    if (NL == 1) begin
                        idx_d        = '0;
                        state_d      = PRIME;
                        seed_ready_d = 1'b0;
`ifdef MASK_GEN_COUNTER_EN
                        cnt_d        = 32'h0;
`endif
                    end else begin
                        idx_d   = IDX_W'(1);
                        state_d = SEED;
                    end
                end else if (state_q == RUN && mask_valid_q && mask_ready) begin
                    lfsr_d = lfsr_adv;
                    for (int b = 0; b < MASK_W; b++)
                        masks_d[b] = lfsr_adv[b / 32][b % 32];
`ifdef MASK_GEN_COUNTER_EN
                    cnt_d = cnt_q + 32'h1;
`endif
                end
            end
            SEED: begin
                if (seed_acc) begin
                    for (int k = 0; k < NL; k++)
                        if (idx_q == IDX_W'(k))
                            lfsr_d[k] = seed_word;
                    if (idx_q == IDX_W'(NL - 1)) begin
                        idx_d        = '0;
                        state_d      = PRIME;
                        seed_ready_d = 1'b0;
`ifdef MASK_GEN_COUNTER_EN
                        cnt_d        = 32'h0;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PRIME: begin
                // Fully loaded seeds: advance once and present the first set.
                lfsr_d = lfsr_adv;
                for (int b = 0; b < MASK_W; b++)
                    masks_d[b] = lfsr_adv[b / 32][b % 32];
                mask_valid_d = 1'b1;
                seed_ready_d = 1'b1;
                state_d      = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset returns to IDLE with the LFSRs at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lfsr_q       <= {NL{32'h1}};
            masks_q      <= '0;
            idx_q        <= '0;
            mask_valid_q <= 1'b0;
            seed_ready_q <= 1'b1;
`ifdef MASK_GEN_COUNTER_EN
            cnt_q        <= 32'h0;
`endif
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            masks_q      <= masks_d;
            idx_q        <= idx_d;
            mask_valid_q <= mask_valid_d;
            seed_ready_q <= seed_ready_d;
`ifdef MASK_GEN_COUNTER_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign seed_ready   = seed_ready_q;
    assign mask_valid   = mask_valid_q;
    assign random_masks = masks_q;
`ifdef MASK_GEN_COUNTER_EN
    assign mask_count   = cnt_q;
`endif

endmodule

// File: doc/mask_gen.md
MASK_GEN -- requirements
Module: mask_gen

Interface
REQ-001 The block SHALL have a parameter d, default 2, giving the masking order (number of random masks per share set).
REQ-002 The block SHALL have a parameter COL_SIZE, default 5, giving the data block width in bits.
REQ-003 The block SHALL have a parameter PAR, default 1, giving the number of parallel blocks.
REQ-004 The block SHALL use derived constants MASK_W = d*COL_SIZE*PAR and NL = ceil(MASK_W/32), the number of internal 32-bit LFSRs.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 seed_valid  in  1  seed word offered.
REQ-008 seed_ready  out  1  seed word accepted when seed_valid and seed_ready are both high at a clock edge.
REQ-009 seed_data  in  32  one LFSR seed word.
REQ-010 mask_valid  out  1  random_masks holds a fresh, unconsumed mask set.
REQ-011 mask_ready  in  1  consumer (share creation stage) takes the mask set.
REQ-012 random_masks  out  MASK_W  d masks, mask i in bits [i*COL_SIZE*PAR +: COL_SIZE*PAR].

Function
REQ-013 The block SHALL have four FSM states: IDLE, SEED, PRIME and RUN.
REQ-014 LFSR k SHALL be a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1 (tap mask 32'h80200003), shifting right, with the feedback taken from bit 0.
REQ-015 Seed words SHALL load LFSR 0, 1, ... NL-1 in order; a seed word of 32'h0 SHALL be loaded as 32'h00000001 to prevent lock-up.
REQ-016 IDLE: seed_ready=1, mask_valid=0; the first accepted seed word loads LFSR 0, then -> SEED (or -> PRIME if NL=1).
REQ-017 SEED: seed_ready=1, mask_valid=0; each accepted word loads the next LFSR; acceptance of word NL-1 -> PRIME.
REQ-018 PRIME: seed_ready=0, mask_valid=0; one cycle long; every LFSR is advanced 32 steps (unrolled combinationally), and random_masks is loaded with the low MASK_W bits of {LFSR NL-1, ..., LFSR 0} after the advance; -> RUN.
REQ-019 The latency from acceptance of the last seed word to mask_valid=1 SHALL be exactly 2 clock edges.
REQ-020 RUN: mask_valid=1 and seed_ready=1.
REQ-021 In RUN, on mask_valid&&mask_ready, the LFSRs SHALL advance 32 steps and random_masks SHALL update at the same edge, giving back-to-back delivery with no bubble.
REQ-022 In RUN without a handshake, random_masks and the LFSRs SHALL hold.
REQ-023 Reseed: an accepted seed word in RUN SHALL take priority over a simultaneous mask handshake; it loads LFSR 0, drops mask_valid at that edge, and enters SEED (or PRIME if NL=1).
REQ-024 A mask set SHALL never be presented twice, and no mask SHALL be derived from a partially loaded seed.
REQ-025 seed_data and mask_ready SHALL be ignored when the corresponding valid/ready qualifier is low.

Reset
REQ-026 During and after rst, the block SHALL be in state IDLE, with all LFSRs = 32'h00000001, random_masks = 0, mask_valid = 0, seed_ready = 1 and the seed index = 0.
REQ-027 rst asserted mid-seed or mid-RUN SHALL discard all seed progress; a full NL-word reseed is required afterwards.

Configuration
REQ-028 When macro MASK_GEN_COUNTER_EN is defined, the block SHALL add the output port mask_count [31:0], which counts completed mask handshakes.
REQ-029 mask_count SHALL reset to 0 on rst, clear to 0 on entry to PRIME, wrap from 32'hFFFFFFFF to 0, and be unaffected by stalls.
REQ-030 When MASK_GEN_COUNTER_EN is undefined, the port and the counter logic SHALL be absent, with all other behaviour identical.

Verification
REQ-031 Reset then seed 32'h00000000 (defaults, NL=1) -> LFSR loaded as 32'h1; mask_valid rises 2 edges after acceptance; random_masks equals the low 10 bits of the 32-step advance of 32'h1, per the C model.
REQ-032 Hold mask_ready=1 for 100 cycles in RUN -> 100 distinct consecutive model values with no gaps; with the macro defined, mask_count=100.
REQ-033 Toggle mask_ready randomly -> random_masks stable while mask_ready=0; the sequence matches the model exactly once per handshake.
REQ-034 d=4, COL_SIZE=5, PAR=4 (MASK_W=80, NL=3): send 3 seed words with a 5-cycle gap after the 2nd -> mask_valid stays 0 until 2 edges after the 3rd word; output matches the model.
REQ-035 In RUN, seed_valid and mask_ready high on the same edge -> seed taken, mask_valid=0 next cycle, no mask handshake counted, new sequence after PRIME.
REQ-036 Assert rst while in SEED after 1 of 3 words -> IDLE, outputs at reset values; the next mask appears only after 3 fresh words.
